deco_3_8_seq: RTL and testbench
===============================

# deco_3_8_seq

Sequenced 3-to-8 decoder: the receive-side counterpart of the 8-to-3 priority encoder. It accepts encoded words `{valid, y[2:0]}` through a valid/ready handshake and queues them in a small FIFO. Each word is replayed as a one-hot pulse on `A[7:0]`, held for a fixed number of cycles. It sits downstream of the encoder to regenerate request lines, for example for strobe fan-out or test playback.

## Interface
- `HOLD`, 4, cycles each decoded word is driven on `A`; legal range 1..15.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept a word; equals `!full`.
- `y`  in  3  encoded index.
- `valid`  in  1  encoder "any input set" flag, stored with `y`.
- `A`  out  8  decoded one-hot output (registered).
- `busy`  out  1  high while the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse in the last cycle a word is driven.
- `level`  out  $clog2(DEPTH)+1  number of FIFO entries currently stored.

## Operation
- Push:
  - A word is pushed when `in_valid && in_ready` at a rising edge.
  - `in_ready` depends only on `full`. A pop in the same cycle does not allow a push when the FIFO is full.
- FIFO:
  - Entries are 4 bits, `{valid, y}`.
  - Read and write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - `full` and `empty` are derived from the pointers.
  - `level` is `wr_ptr - rd_ptr`.
- Decode of a popped entry:
  - `valid=1`: `A = 8'b1 << y`.
  - `valid=0`: `A = 8'h00`. The slot is still consumed and still timed: `busy=1`, and `done` pulses.
- FSM states: IDLE, DRIVE, GAP. GAP exists only with the macro (see Configuration).
  - IDLE, `!empty`: pop, load `A`, load `cnt = HOLD-1`, go to DRIVE.
  - IDLE, `empty`: `A = 0`.
  - DRIVE, `cnt != 0`: `cnt` decrements; `A` holds.
  - DRIVE, `cnt == 0`: assert `done`. Then, if `!empty`, pop and load the next word back-to-back with no idle cycle. Otherwise set `A = 0` and return to IDLE.
- Simultaneous push into an empty FIFO and IDLE check: the pop uses the registered `empty`, so the new word is popped on the following edge.
- Reset is synchronous, active-low:
  - `A = 0`, `busy = 0`, `done = 0`, `level = 0`, `in_ready = 1`.
  - Both FIFO pointers are 0 and the FSM is in IDLE.
  - Reset mid-DRIVE discards the word being driven and every queued word at that edge. None of them ever appears on `A`.
  - `in_valid` is ignored while `rst_n = 0`.

## Timing
- Latency: a word accepted at edge N into an idle block appears on `A` after edge N+1.
- Hold: each word stays on `A` for exactly `HOLD` cycles. `done` is high during the last of them.
- Back-to-back words (no macro): output words are contiguous, with no zero cycle between them.
- Throughput: one word per `HOLD` cycles.
- `level` and `in_ready` reflect the pointers after each edge:
  - a push makes `level` +1 on the next cycle;
  - a pop makes `level` −1;
  - a simultaneous push and pop leaves `level` unchanged.
- All outputs are registered. There is no combinational path from inputs to outputs except `in_ready`, which depends only on `full`, a registered value.

## Configuration
- Macro: `DEC_GAP_EN`.
- Defined:
  - After `done`, the FSM always enters GAP for exactly one cycle, with `A = 0` and `busy = 1`.
  - From GAP it pops the next word if `!empty`, otherwise it goes to IDLE.
  - Throughput becomes one word per `HOLD+1` cycles.
- Undefined: GAP is not synthesized, and DRIVE chains directly to the next word.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with `in_valid=1`. Required: `A=8'h00`, `busy=0`, `done=0`, `level=0`, `in_ready=1`, and nothing is queued.
- Single word (`HOLD=4`): push `y=5`, `valid=1` at edge N. Required:
  - `A=8'h20` during cycles N+1..N+4, and `done` is high only in N+4;
  - `A=8'h00` and `busy=0` from N+5.
- Null word: push `y=3`, `valid=0`. Required: `A=8'h00` throughout, `busy=1` for 4 cycles, `done` pulses once.
- Burst and backpressure (`DEPTH=4`): hold `in_valid=1` with `y=0..5` applied in order. Required:
  - `in_ready` drops once `level=4`;
  - `A` sequence is 01, 02, 04, 08, 10, 20, each held 4 cycles, contiguous, with no loss or duplication.
- Reset mid-operation: during DRIVE of `y=7` with 2 words queued, pulse `rst_n=0` for 1 cycle. Required: `A=8'h00` and `level=0` after that edge, and the queued words never appear.
- `DEC_GAP_EN` defined: push `y=1` and `y=2` back-to-back. Required: 4 cycles of `8'h02`, 1 cycle of `8'h00`, then 4 cycles of `8'h04`.

Source files
------------

// File: rtl/deco_3_8_seq.sv
// Sequenced 3-to-8 decoder: queues {valid, y} words in a FIFO and replays each as a one-hot A held HOLD cycles.
// Optional macro DEC_GAP_EN inserts a one-cycle zero gap after every word.
module deco_3_8_seq #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               y,
    input  logic                     valid,
    output logic [7:0]               A,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level,
    output logic [1:0]               o_dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [3:0] CNT_LOAD = 4'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1
`ifdef DEC_GAP_EN
        ,
        S_GAP   = 2'd2
`endif
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [7:0]    r_a;
    logic          r_done;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]    r_mem [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_head;
    logic [7:0]    w_dec;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready is !full from registered pointers only, so a same-cycle pop never frees a slot.
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_dec    = w_head[3] ? (8'b1 << w_head[2:0]) : 8'h00;

    assign in_ready    = !w_full;
    assign level       = r_wr_ptr - r_rd_ptr;
    assign A           = r_a;
    assign done        = r_done;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = !w_empty;
`ifdef DEC_GAP_EN
            S_DRIVE: w_pop = 1'b0;
            S_GAP:   w_pop = !w_empty;
`else
            S_DRIVE: w_pop = (r_cnt == 4'd0) && !w_empty;
`endif
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {valid, y};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_a      <= 8'h00;
            r_done   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_done <= 1'b0;
            if (w_pop) begin
                // done is raised on the edge that starts the final held cycle
                r_a     <= w_dec;
                r_cnt   <= CNT_LOAD;
                r_done  <= (HOLD == 1);
                r_state <= S_DRIVE;
            end else begin
                case (r_state)
                    S_DRIVE: begin
                        if (r_cnt != 4'd0) begin
                            r_cnt  <= r_cnt - 4'd1;
                            r_done <= (r_cnt == 4'd1);
                        end else begin
                            r_a <= 8'h00;
`ifdef DEC_GAP_EN
                            r_state <= S_GAP;
`else
                            r_state <= S_IDLE;
`endif
                        end
                    end
                    default: begin
                        r_a     <= 8'h00;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_deco_3_8_seq.sv
// Bench for deco_3_8_seq: directed scenarios plus random traffic against a timeline model of the output slots.
module tb_deco_3_8_seq;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;
`ifdef DEC_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] y = 3'd0;
    logic       valid = 1'b0;
    logic [7:0] A;
    logic       busy;
    logic       done;
    logic [2:0] level;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // model state: queued words, current output slot start edge, earliest next start edge
    logic [3:0] exp_q[$];
    logic [3:0] cur_w = 4'h0;
    int         cur_p = -100;
    int         next_free = 0;
    int         e = 0;

    deco_3_8_seq #(.HOLD(HOLD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .valid(valid), .A(A), .busy(busy), .done(done),
        .level(level), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [2:0] yy, input logic vl, input logic rn,
                        output logic acc);
        int         cb;
        logic [7:0] ea;
        logic [7:0] one;
        logic       eb;
        logic       ed;
        in_valid = v;
        y        = yy;
        valid    = vl;
        rst_n    = rn;
        @(posedge clk);
        e++;
        one = 8'd1;
        acc = 1'b0;
        if (!rn) begin
            exp_q.delete();
            cur_p     = -100;
            next_free = 0;
        end else begin
            cb = exp_q.size();
            if (cb > 0 && e >= next_free) begin
                cur_w     = exp_q.pop_front();
                cur_p     = e;
                next_free = e + HOLD + GAP;
            end
            acc = v && (cb < DEPTH);
            if (acc) exp_q.push_back({vl, yy});
        end
        if (e >= cur_p && e <= cur_p + HOLD - 1) begin
            ea = cur_w[3] ? (one << cur_w[2:0]) : 8'h00;
            eb = 1'b1;
            ed = (e == cur_p + HOLD - 1);
        end else begin
            ea = 8'h00;
            eb = (GAP == 1) && (e == cur_p + HOLD);
            ed = 1'b0;
        end
        #1;
        check("A", 32'(A), 32'(ea));
        check("busy", 32'(busy), 32'(eb));
        check("done", 32'(done), 32'(ed));
        check("level", 32'(level), 32'(exp_q.size()));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 1'b0, 1'b1, acc);
    endtask

    task automatic push_word(input logic [2:0] yy, input logic vl);
        logic acc;
        int   tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 40) begin
            tick(1'b1, yy, vl, 1'b1, acc);
            tries++;
        end
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic acc;
        // reset with in_valid asserted: nothing may be queued
        tick(1'b1, 3'd6, 1'b1, 1'b0, acc);
        tick(1'b1, 3'd6, 1'b1, 1'b0, acc);
        idle(2);

        // single word and null word
        push_word(3'd5, 1'b1);
        idle(7);
        push_word(3'd3, 1'b0);
        idle(7);

        // burst with backpressure
        for (int k = 0; k < 6; k++) push_word(3'(k), 1'b1);
        idle(30);

        // reset mid-DRIVE of y=7 with two words queued
        push_word(3'd7, 1'b1);
        push_word(3'd1, 1'b1);
        push_word(3'd2, 1'b1);
        tick(1'b0, 3'd0, 1'b0, 1'b0, acc);
        idle(12);

        // back-to-back pair (exercises the gap when enabled)
        push_word(3'd1, 1'b1);
        push_word(3'd2, 1'b1);
        idle(14);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) != 0), acc);
        end
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
